// File: rtl/apb4_req_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb4_req_bridge_pkg
// Shared types and constants for the APB4 request bridge.
//   bridge_state_e    : transfer FSM states (IDLE -> SETUP -> ACCESS -> RESP)
//   APB4_PROT_DEFAULT : pprot value driven on every transfer
//   TMO_CNT_W         : width of the optional ACCESS-phase timeout counter
// -----------------------------------------------------------------------------
package apb4_req_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } bridge_state_e;

   localparam logic [2:0] APB4_PROT_DEFAULT = 3'b000;
   localparam int         TMO_CNT_W         = 8;

endpackage

// File: rtl/apb4_req_bridge_tmo.sv
// -----------------------------------------------------------------------------
// apb4_req_bridge_tmo
// ACCESS-phase timeout counter for apb4_req_bridge (only instantiated when
// APB4_REQ_BRIDGE_TMO_EN is defined).
// Ports:
//   pclk_i, presetn_i : clock, synchronous active-low reset
//   clr_i             : clear the count (asserted the cycle before ACCESS)
//   en_i              : one ACCESS cycle with pready low
//   expired_o         : high during the TMO_CYCLES-th waiting ACCESS cycle
// -----------------------------------------------------------------------------
module apb4_req_bridge_tmo
   import apb4_req_bridge_pkg::*;
#(
   parameter int TMO_CYCLES = 255
) (
   input  logic pclk_i,
   input  logic presetn_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   // cnt_q holds the number of waiting cycles already completed, so the
   // current waiting cycle is the last one when cnt_q == TMO_CYCLES-1.
   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO_CYCLES - 1);
   localparam logic [TMO_CNT_W-1:0] CNT_MAX  = {TMO_CNT_W{1'b1}};

   logic [TMO_CNT_W-1:0] cnt_q;
   logic [TMO_CNT_W-1:0] cnt_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {TMO_CNT_W{1'b0}};
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + TMO_CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge pclk_i) begin
      if (!presetn_i) begin
         cnt_q <= {TMO_CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == TMO_LAST);

endmodule

// File: rtl/apb4_req_bridge.sv
// -----------------------------------------------------------------------------
// apb4_req_bridge
// Converts a valid/ready request channel into single APB4 SETUP/ACCESS
// transfers and returns a valid/ready response. One transfer in flight.
// Optional feature macro: APB4_REQ_BRIDGE_TMO_EN (ACCESS-phase timeout that
// returns an error response after TMO_CYCLES waiting cycles).
// Ports:
//   pclk, presetn            : clock, synchronous active-low reset
//   req_valid_i/req_ready_o  : request handshake
//   req_write_i, req_addr_i, req_wdata_i, req_wstrb_i : request payload
//   rsp_valid_o/rsp_ready_i  : response handshake
//   rsp_rdata_o, rsp_err_o   : read data (0 on writes/errors), error flag
//   paddr..pstrb             : APB4 master outputs
//   pready, prdata, pslverr  : APB4 slave inputs
// -----------------------------------------------------------------------------
module apb4_req_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TMO_CYCLES = 255
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_write_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [2:0]              pprot,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic                    pready,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pslverr
);

   import apb4_req_bridge_pkg::*;

   localparam int STRB_W = DATA_WIDTH / 8;

   if (DATA_WIDTH != 32) begin : g_dw_chk
      $error("apb4_req_bridge: DATA_WIDTH must be 32");
   end
   if (ADDR_WIDTH < 3) begin : g_aw_chk
      $error("apb4_req_bridge: ADDR_WIDTH must be >= 3");
   end
   if ((TMO_CYCLES < 1) || (TMO_CYCLES > 255)) begin : g_tmo_chk
      $error("apb4_req_bridge: TMO_CYCLES must be in 1..255");
   end

   bridge_state_e           state_q, state_d;
   logic                    ready_q, psel_q, penable_q, rsp_valid_q;
   logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
   logic                    pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]       pstrb_q, pstrb_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic                    accept_s;
   logic                    tmo_expired_s;

   assign accept_s = (state_q == IDLE) && req_valid_i;

`ifdef APB4_REQ_BRIDGE_TMO_EN
   apb4_req_bridge_tmo #(
      .TMO_CYCLES (TMO_CYCLES)
   ) u_tmo (
      .pclk_i    (pclk),
      .presetn_i (presetn),
      .clr_i     (state_q == SETUP),
      .en_i      ((state_q == ACCESS) && !pready),
      .expired_o (tmo_expired_s)
   );
`else
   assign tmo_expired_s = 1'b0;
`endif

   // Next-state logic for the transfer FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            // pready wins over a timeout in the same cycle.
            if (pready || tmo_expired_s) begin
               state_d = RESP;
            end else begin
               state_d = ACCESS;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request capture: word-aligned address, write data/strobes zeroed on reads.
   always_comb begin
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      if (accept_s) begin
         paddr_d  = req_addr_i & ~(ADDR_WIDTH'(3));
         pwrite_d = req_write_i;
         if (req_write_i) begin
            pwdata_d = req_wdata_i;
            pstrb_d  = req_wstrb_i;
         end else begin
            pwdata_d = {DATA_WIDTH{1'b0}};
            pstrb_d  = {STRB_W{1'b0}};
         end
      end else begin
         paddr_d  = paddr_q;
         pwrite_d = pwrite_q;
      end
   end

   // Response capture: read data only for error-free reads; timeout is an error.
   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if ((state_q == ACCESS) && pready) begin
         err_d = pslverr;
         if (!pwrite_q && !pslverr) begin
            rdata_d = prdata;
         end else begin
            rdata_d = {DATA_WIDTH{1'b0}};
         end
      end else if ((state_q == ACCESS) && tmo_expired_s) begin
         err_d   = 1'b1;
         rdata_d = {DATA_WIDTH{1'b0}};
      end else if ((state_q == RESP) && rsp_ready_i) begin
         err_d   = 1'b0;
         rdata_d = {DATA_WIDTH{1'b0}};
      end else begin
         err_d   = err_q;
         rdata_d = rdata_q;
      end
   end

   // State, request and response registers; handshake/APB strobes decoded
   // from the next state so every output comes straight from a flop.
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q     <= IDLE;
         ready_q     <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         paddr_q     <= {ADDR_WIDTH{1'b0}};
         pwrite_q    <= 1'b0;
         pwdata_q    <= {DATA_WIDTH{1'b0}};
         pstrb_q     <= {STRB_W{1'b0}};
         rdata_q     <= {DATA_WIDTH{1'b0}};
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= (state_d == IDLE);
         psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
         penable_q   <= (state_d == ACCESS);
         rsp_valid_q <= (state_d == RESP);
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
   assign paddr       = paddr_q;
   assign pprot       = APB4_PROT_DEFAULT;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign pstrb       = pstrb_q;

endmodule

// File: tb/tb_apb4_req_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb4_req_bridge
// Directed self-checking bench for apb4_req_bridge. The APB slave side is
// driven directly from the stimulus sequence. Build with
// APB4_REQ_BRIDGE_TMO_EN defined to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_apb4_req_bridge;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        req_valid_i, req_ready_o, req_write_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [3:0]  req_wstrb_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic [31:0] paddr, pwdata, prdata;
   logic [2:0]  pprot;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;

   int n_checks = 0;
   int n_fail   = 0;

   apb4_req_bridge #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .TMO_CYCLES (4)
   ) dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_wstrb_i (req_wstrb_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .paddr       (paddr),
      .pprot       (pprot),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .pwdata      (pwdata),
      .pstrb       (pstrb),
      .pready      (pready),
      .prdata      (prdata),
      .pslverr     (pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws);
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_addr_i  = addr;
      req_wdata_i = wd;
      req_wstrb_i = ws;
   endtask

   initial begin
      presetn     = 1'b0;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_addr_i  = 32'h0;
      req_wdata_i = 32'h0;
      req_wstrb_i = 4'h0;
      rsp_ready_i = 1'b1;
      pready      = 1'b0;
      prdata      = 32'h0;
      pslverr     = 1'b0;

      // ---- reset ----
      tick();
      tick();
      check("rst_psel", {31'd0, psel}, 32'd0);
      check("rst_penable", {31'd0, penable}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      presetn = 1'b1;
      tick();
      check("rst_ready", {31'd0, req_ready_o}, 32'd1);
      check("rst_paddr", paddr, 32'h0);
      check("rst_pwdata", pwdata, 32'h0);
      check("rst_rdata", rsp_rdata_o, 32'h0);
      check("rst_err", {31'd0, rsp_err_o}, 32'd0);

      // ---- read, zero wait states, unaligned address ----
      set_req(1'b0, 32'h0000_0006, 32'h5555_5555, 4'hF);
      pready = 1'b1;
      prdata = 32'hDEAD_BEEF;
      tick();                                   // T+1 SETUP
      req_valid_i = 1'b0;
      check("rd_setup_psel", {31'd0, psel}, 32'd1);
      check("rd_setup_penable", {31'd0, penable}, 32'd0);
      check("rd_setup_ready", {31'd0, req_ready_o}, 32'd0);
      check("rd_paddr", paddr, 32'h0000_0004);
      check("rd_pstrb", {28'd0, pstrb}, 32'd0);
      check("rd_pwdata", pwdata, 32'h0);
      check("rd_pwrite", {31'd0, pwrite}, 32'd0);
      check("rd_pprot", {29'd0, pprot}, 32'd0);
      tick();                                   // T+2 ACCESS
      check("rd_access_penable", {31'd0, penable}, 32'd1);
      check("rd_access_rsp", {31'd0, rsp_valid_o}, 32'd0);
      tick();                                   // T+3 RESP
      check("rd_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("rd_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
      check("rd_err", {31'd0, rsp_err_o}, 32'd0);
      check("rd_resp_psel", {31'd0, psel}, 32'd0);
      tick();                                   // back in IDLE
      check("rd_idle_ready", {31'd0, req_ready_o}, 32'd1);
      check("rd_idle_rsp", {31'd0, rsp_valid_o}, 32'd0);

      // ---- write with 3 wait states ----
      set_req(1'b1, 32'h0000_0008, 32'h1234_5678, 4'b0011);
      pready = 1'b0;
      prdata = 32'hAAAA_5555;
      tick();                                   // T+1 SETUP
      req_valid_i = 1'b0;
      check("wr_paddr", paddr, 32'h0000_0008);
      check("wr_pwrite", {31'd0, pwrite}, 32'd1);
      tick();                                   // T+2 ACCESS
      for (int i = 0; i < 3; i++) begin         // T+2..T+4 waiting
         check("wr_wait_penable", {31'd0, penable}, 32'd1);
         check("wr_wait_psel", {31'd0, psel}, 32'd1);
         check("wr_wait_paddr", paddr, 32'h0000_0008);
         check("wr_wait_pwdata", pwdata, 32'h1234_5678);
         check("wr_wait_pstrb", {28'd0, pstrb}, 32'h3);
         check("wr_wait_rsp", {31'd0, rsp_valid_o}, 32'd0);
         tick();
      end
      check("wr_t5_penable", {31'd0, penable}, 32'd1);  // T+5 ACCESS, pready
      pready = 1'b1;
      tick();                                   // T+6 RESP
      check("wr_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("wr_rdata", rsp_rdata_o, 32'h0);
      check("wr_err", {31'd0, rsp_err_o}, 32'd0);
      tick();

      // ---- read with slave error ----
      set_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      pslverr = 1'b1;
      prdata  = 32'hFFFF_FFFF;
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();                                   // T+3 RESP
      check("err_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("err_err", {31'd0, rsp_err_o}, 32'd1);
      check("err_rdata", rsp_rdata_o, 32'h0);
      tick();
      pslverr = 1'b0;

      // ---- response back-pressure and second request held off ----
      rsp_ready_i = 1'b0;
      set_req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
      prdata = 32'h0BAD_F00D;
      tick();
      req_valid_i = 1'b0;
      tick();
      tick();                                   // T+3 RESP
      set_req(1'b1, 32'h0000_0040, 32'hCAFE_0001, 4'hF);
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
         check("bp_rdata", rsp_rdata_o, 32'h0BAD_F00D);
         check("bp_err", {31'd0, rsp_err_o}, 32'd0);
         check("bp_ready", {31'd0, req_ready_o}, 32'd0);
         check("bp_psel", {31'd0, psel}, 32'd0);
         tick();
      end
      rsp_ready_i = 1'b1;
      tick();                                   // IDLE after handshake
      check("bp_idle_ready", {31'd0, req_ready_o}, 32'd1);
      check("bp_idle_rsp", {31'd0, rsp_valid_o}, 32'd0);
      check("bp_idle_psel", {31'd0, psel}, 32'd0);
      tick();                                   // second request in SETUP
      req_valid_i = 1'b0;
      check("bp2_psel", {31'd0, psel}, 32'd1);
      check("bp2_paddr", paddr, 32'h0000_0040);
      check("bp2_pwdata", pwdata, 32'hCAFE_0001);
      tick();
      tick();
      check("bp2_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("bp2_rdata", rsp_rdata_o, 32'h0);
      tick();

      // ---- reset during ACCESS ----
      set_req(1'b1, 32'h0000_0030, 32'h7777_8888, 4'hF);
      pready = 1'b0;
      tick();
      req_valid_i = 1'b0;
      tick();                                   // ACCESS
      check("ra_penable", {31'd0, penable}, 32'd1);
      presetn = 1'b0;
      tick();
      check("ra_psel", {31'd0, psel}, 32'd0);
      check("ra_penable0", {31'd0, penable}, 32'd0);
      check("ra_rsp", {31'd0, rsp_valid_o}, 32'd0);
      check("ra_paddr", paddr, 32'h0);
      check("ra_pwdata", pwdata, 32'h0);
      check("ra_pwrite", {31'd0, pwrite}, 32'd0);
      presetn = 1'b1;
      pready  = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("ra_ready", {31'd0, req_ready_o}, 32'd1);
         check("ra_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
         check("ra_no_psel", {31'd0, psel}, 32'd0);
         tick();
      end

      // ---- pready stuck low ----
      set_req(1'b0, 32'h0000_0050, 32'h0, 4'h0);
      pready = 1'b0;
      prdata = 32'h1357_9BDF;
      tick();                                   // T+1
      req_valid_i = 1'b0;
`ifdef APB4_REQ_BRIDGE_TMO_EN
      tick();                                   // T+2 first ACCESS
      tick();
      tick();
      tick();                                   // T+5 fourth ACCESS
      check("tmo_last_penable", {31'd0, penable}, 32'd1);
      check("tmo_last_rsp", {31'd0, rsp_valid_o}, 32'd0);
      tick();                                   // T+6 RESP
      check("tmo_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check("tmo_err", {31'd0, rsp_err_o}, 32'd1);
      check("tmo_rdata", rsp_rdata_o, 32'h0);
      check("tmo_psel", {31'd0, psel}, 32'd0);
      check("tmo_penable", {31'd0, penable}, 32'd0);
      tick();
      check("tmo_idle_ready", {31'd0, req_ready_o}, 32'd1);
`else
      for (int i = 2; i <= 100; i++) begin
         tick();
      end                                       // T+100
      check("stuck_psel", {31'd0, psel}, 32'd1);
      check("stuck_penable", {31'd0, penable}, 32'd1);
      check("stuck_rsp", {31'd0, rsp_valid_o}, 32'd0);
      check("stuck_ready", {31'd0, req_ready_o}, 32'd0);
      presetn = 1'b0;
      tick();
      presetn = 1'b1;
      tick();
      check("stuck_rst_ready", {31'd0, req_ready_o}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
